// File: rtl/gf_ctrl_pkg.sv
// Shared definitions for the GF(p) control blocks.
// Holds the scheduler FSM states and the default multiplier geometry.
package gf_ctrl_pkg;

   // Default operand width and multiplier latency; the multiplier
   // wrapper uses the same constants so the two cannot drift apart.
   localparam int GF_WIDTH    = 256;
   localparam int GF_MULT_LAT = 257;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit
// at or after the pointer, wrapping modulo N_REQ.
// Ports:
//   req_i     - request vector
//   ptr_i     - highest-priority index (held by the caller)
//   gnt_o     - one-hot grant
//   gnt_idx_o - index of the granted requester
//   any_o     - at least one request is pending
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IW-1:0]    gnt_idx_o,
   output logic             any_o
);

   always_comb begin
      int k;
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      k         = 0;
      for (int i = 0; i < N_REQ; i++) begin
         // ptr_i < N_REQ, so one subtraction is enough to wrap
         k = int'(ptr_i) + i;
         if (k >= N_REQ) begin
            k = k - N_REQ;
         end
         if (!any_o && req_i[k]) begin
            any_o     = 1'b1;
            gnt_o[k]  = 1'b1;
            gnt_idx_o = IW'(k);
         end
      end
   end

endmodule

// File: rtl/gf_mult_scheduler.sv
// Shares one GF(p) multiplier between N_REQ requesters: round-robin
// accept, start pulse, fixed-latency wait, valid/ready response.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake, one bit per requester
//   req_a/req_b/req_p    - packed operands, requester k at [k*WIDTH +: WIDTH]
//   mul_start            - one-cycle start pulse to the multiplier
//   mul_a/mul_b/mul_p    - operands held stable until the next grant
//   mul_result           - multiplier product, valid MULT_LAT after start
//   rsp_valid/rsp_ready  - one-hot response handshake to the granted requester
//   rsp_data             - captured product
//   busy                 - scheduler is not idle
module gf_mult_scheduler
   import gf_ctrl_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = GF_WIDTH,
   parameter int MULT_LAT = GF_MULT_LAT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*WIDTH-1:0] req_p,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   mul_start,
   output logic [WIDTH-1:0]       mul_a,
   output logic [WIDTH-1:0]       mul_b,
   output logic [WIDTH-1:0]       mul_p,
   input  logic [WIDTH-1:0]       mul_result,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic                   busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(MULT_LAT);

   if (MULT_LAT < 2) begin : g_bad_lat
      $error("gf_mult_scheduler: MULT_LAT must be >= 2");
   end
   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("gf_mult_scheduler: N_REQ must be in 2..8");
   end

   sched_state_e     state_q, state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    grant_id_q, grant_id_d;
   logic [CW-1:0]    lat_cnt_q, lat_cnt_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic [WIDTH-1:0] mul_p_q, mul_p_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;

   logic [WIDTH-1:0] a_arr [N_REQ];
   logic [WIDTH-1:0] b_arr [N_REQ];
   logic [WIDTH-1:0] p_arr [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign a_arr[k] = req_a[k*WIDTH +: WIDTH];
      assign b_arr[k] = req_b[k*WIDTH +: WIDTH];
      assign p_arr[k] = req_p[k*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (gnt_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         lat_cnt_q  <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_p_q    <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         lat_cnt_q  <= lat_cnt_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         mul_p_q    <= mul_p_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      lat_cnt_d  = lat_cnt_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      mul_p_d    = mul_p_q;
      rsp_data_d = rsp_data_q;
      unique case (state_q)
         ST_IDLE: begin
            // grant and latch in the same cycle; no arbitration bubble
            if (gnt_any) begin
               state_d    = ST_START;
               grant_id_d = gnt_idx;
               mul_a_d    = a_arr[gnt_idx];
               mul_b_d    = b_arr[gnt_idx];
               mul_p_d    = p_arr[gnt_idx];
               rr_ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ?
                            '0 : gnt_idx + IW'(1);
            end
         end
         ST_START: begin
            lat_cnt_d = CW'(MULT_LAT - 1);
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            // lat_cnt reaches 0 exactly MULT_LAT cycles after start
            if (lat_cnt_q == '0) begin
               rsp_data_d = mul_result;
               state_d    = ST_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - CW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready[grant_id_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      mul_start = 1'b0;
      rsp_valid = '0;
      busy      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // no accept while reset is held: the grant would be lost
            if (!rst) begin
               req_ready = gnt;
            end
         end
         ST_START: begin
            mul_start = 1'b1;
            busy      = 1'b1;
         end
         ST_WAIT: begin
            busy = 1'b1;
         end
         ST_RESP: begin
            busy      = 1'b1;
            rsp_valid = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
         end
         default: ;
      endcase
   end

   assign mul_a    = mul_a_q;
   assign mul_b    = mul_b_q;
   assign mul_p    = mul_p_q;
   assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_gf_mult_scheduler.sv
// Self-checking bench for gf_mult_scheduler with a behavioural
// fixed-latency modular multiplier model.
module tb_gf_mult_scheduler;

   localparam int N = 4;
   localparam int W = 256;
   localparam int L = 257;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_a, req_b, req_p;
   logic           mul_start, busy;
   logic [W-1:0]   mul_a, mul_b, mul_p, mul_result, rsp_data;

   logic [W-1:0] opa [N];
   logic [W-1:0] opb [N];
   logic [W-1:0] opp [N];

   always_comb begin
      req_a = '0;
      req_b = '0;
      req_p = '0;
      for (int k = 0; k < N; k++) begin
         req_a[k*W +: W] = opa[k];
         req_b[k*W +: W] = opb[k];
         req_p[k*W +: W] = opp[k];
      end
   end

   gf_mult_scheduler #(
      .N_REQ    (N),
      .WIDTH    (W),
      .MULT_LAT (L)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_p      (req_p),
      .req_ready  (req_ready),
      .mul_start  (mul_start),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .mul_result (mul_result),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   function automatic logic [W-1:0] mulmod(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] p);
      logic [2*W-1:0] x;
      logic [2*W-1:0] m;
      x = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      m = x % {{W{1'b0}}, p};
      return m[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd256();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // multiplier model: product shows up L cycles after the start cycle,
   // junk before that so an early capture is visible
   logic [W-1:0] junk = {8{32'hDEADBEEF}};
   logic [W-1:0] mres;
   int           mcnt = 0;
   always @(posedge clk) begin
      if (rst) begin
         mcnt <= 0;
      end else if (mul_start) begin
         mcnt <= 1;
         mres <= mulmod(mul_a, mul_b, mul_p);
      end else if (mcnt > 0 && mcnt < 100000) begin
         mcnt <= mcnt + 1;
      end
   end
   assign mul_result = (mcnt >= L) ? mres : junk;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_ptr = 0;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req_ready"}, W'(req_ready), '0);
      chk({tag, "_mul_start"}, W'(mul_start), '0);
      chk({tag, "_rsp_valid"}, W'(rsp_valid), '0);
      chk({tag, "_busy"}, W'(busy), '0);
      chk({tag, "_mul_a"}, mul_a, '0);
      chk({tag, "_mul_b"}, mul_b, '0);
      chk({tag, "_mul_p"}, mul_p, '0);
      chk({tag, "_rsp_data"}, rsp_data, '0);
   endtask

   // Called in an IDLE cycle with req_valid already driven; returns in
   // the following IDLE cycle.
   task automatic run_txn(input int g, input logic [W-1:0] dexp,
                          input int hold, input bit keep,
                          input bit scramble);
      logic [W-1:0] a0, b0, p0, rd;
      logic [N-1:0] rv, gmask;
      int  n;
      bit  ok;
      gmask = N'(1) << g;
      #1;
      chk("req_ready_grant", W'(req_ready), W'(gmask));
      chk("busy_idle", W'(busy), '0);
      exp_ptr = (g + 1) % N;
      cyc();
      if (!keep) req_valid[g] = 1'b0;
      #1;
      chk("mul_start", W'(mul_start), W'(1));
      chk("req_ready_start", W'(req_ready), '0);
      chk("busy_start", W'(busy), W'(1));
      chk("mul_a_latch", mul_a, opa[g]);
      chk("mul_b_latch", mul_b, opb[g]);
      chk("mul_p_latch", mul_p, opp[g]);
      a0 = mul_a;
      b0 = mul_b;
      p0 = mul_p;
      ok = 1'b1;
      n  = 0;
      do begin
         cyc();
         if (scramble) begin
            opa[g]    = rnd256();
            opb[g]    = rnd256();
            opp[g]    = rnd256();
            rsp_ready = N'($urandom) & ~gmask;
         end
         #1;
         n++;
         if (mul_a !== a0 || mul_b !== b0 || mul_p !== p0 ||
             mul_start !== 1'b0 || req_ready !== '0) ok = 1'b0;
      end while (rsp_valid === '0 && n < L + 20);
      chk("ops_stable_wait", W'(ok), W'(1));
      chk("rsp_latency", W'(n), W'(L + 1));
      chk("rsp_valid", W'(rsp_valid), W'(gmask));
      chk("rsp_data", rsp_data, dexp);
      rv = rsp_valid;
      rd = rsp_data;
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         cyc();
         rsp_ready = N'($urandom) & ~gmask;
         #1;
         if (rsp_valid !== rv || rsp_data !== rd ||
             req_ready !== '0 || busy !== 1'b1) ok = 1'b0;
      end
      if (hold > 0) chk("rsp_hold_stable", W'(ok), W'(1));
      rsp_ready = gmask;
      #1;
      chk("rsp_valid_ack", W'(rsp_valid), W'(rv));
      chk("req_ready_ack", W'(req_ready), '0);
      cyc();
      rsp_ready = '0;
   endtask

   typedef struct {
      int           g;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;
      logic [W-1:0] exp;
      int           hold;
      bit           scr;
   } vec_t;

   vec_t         tbl [4];
   logic [W-1:0] pbig;
   logic [W-1:0] ex [N];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, W'(3),      W'(5),   W'(7),       W'(1),      0,  1'b0};
      tbl[1] = '{1, W'(10),     W'(10),  W'(13),      W'(9),      10, 1'b0};
      tbl[2] = '{2, W'(123456), W'(789), W'(1000003), W'(406493), 2,  1'b1};
      tbl[3] = '{3, W'(6),      W'(6),   W'(7),       W'(1),      1,  1'b0};
      pbig = (W'(1) << 255) - W'(19);

      req_valid = '0;
      rsp_ready = '0;
      for (int k = 0; k < N; k++) begin
         opa[k] = '0;
         opb[k] = '0;
         opp[k] = W'(1);
      end

      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      #1;
      chk_reset_outs("reset");

      // single requests, incl. backpressure and ignored inputs
      for (int i = 0; i < 4; i++) begin
         opa[tbl[i].g] = tbl[i].a;
         opb[tbl[i].g] = tbl[i].b;
         opp[tbl[i].g] = tbl[i].p;
         req_valid = N'(1) << tbl[i].g;
         run_txn(tbl[i].g, tbl[i].exp, tbl[i].hold, 1'b0, tbl[i].scr);
         req_valid = '0;
      end

      // all requesters continuously: grants 0,1,2,3,0
      for (int k = 0; k < N; k++) begin
         opa[k] = rnd256() % pbig;
         opb[k] = rnd256() % pbig;
         opp[k] = pbig;
         ex[k]  = mulmod(opa[k], opb[k], opp[k]);
      end
      req_valid = '1;
      for (int i = 0; i < 5; i++) run_txn(i % N, ex[i % N], 0, 1'b1, 1'b0);
      req_valid = '0;

      // pointer wrap: reach rr_ptr=3, then 0101 -> 0, then 2
      opa[0] = W'(7); opb[0] = W'(8); opp[0] = W'(11);
      opa[2] = W'(9); opb[2] = W'(9); opp[2] = W'(11);
      req_valid = 4'b0100;
      run_txn(2, W'(4), 0, 1'b0, 1'b0);
      req_valid = 4'b0101;
      run_txn(0, W'(1), 0, 1'b1, 1'b0);
      run_txn(2, W'(4), 0, 1'b1, 1'b0);
      req_valid = '0;

      // reset 100 cycles after mul_start
      begin
         bit ok;
         opa[1] = W'(5); opb[1] = W'(5); opp[1] = W'(11);
         req_valid = 4'b0010;
         #1;
         chk("rst_txn_grant", W'(req_ready), W'(4'b0010));
         cyc();
         req_valid = '0;
         #1;
         chk("rst_txn_start", W'(mul_start), W'(1));
         repeat (100) cyc();
         rst = 1'b1;
         cyc();
         rst = 1'b0;
         #1;
         chk_reset_outs("midwait_rst");
         exp_ptr = 0;
         ok = 1'b1;
         repeat (L + 10) begin
            cyc();
            #1;
            if (rsp_valid !== '0 || busy !== 1'b0) ok = 1'b0;
         end
         chk("no_rsp_after_rst", W'(ok), W'(1));
         // rr_ptr back at 0: 1110 must grant requester 1
         req_valid = 4'b1110;
         run_txn(1, W'(3), 0, 1'b0, 1'b0);
         req_valid = '0;
      end

      // random traffic against the round-robin rule
      for (int t = 0; t < 8; t++) begin
         logic [N-1:0] rv;
         int g;
         for (int k = 0; k < N; k++) begin
            opa[k] = rnd256() % pbig;
            opb[k] = rnd256() % pbig;
            opp[k] = pbig;
         end
         rv = N'($urandom_range(1, (1 << N) - 1));
         g = -1;
         for (int i = 0; i < N; i++) begin
            int k;
            k = (exp_ptr + i) % N;
            if (g < 0 && rv[k]) g = k;
         end
         req_valid = rv;
         run_txn(g, mulmod(opa[g], opb[g], opp[g]),
                 $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
         req_valid = '0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
